// File: rtl/store_rmw_ctrl.sv
// Store-path read-modify-write controller.
// Handles one SW/SH/SB request at a time. A word store writes B straight
// through. A byte or halfword store reads the target word, splices the low
// byte or halfword of B into it, and writes the merged word back.
module store_rmw_ctrl #(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       b_in,
   input  logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] SizeWord = 2'b00;
   localparam logic [1:0] SizeByte = 2'b01;
   localparam logic [1:0] SizeHalf = 2'b10;

   // Counter only has to reach READ_LATENCY-1; keep at least one bit.
   localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCapture,
      StWrite,
      StError
   } state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic [31:0]       b_q;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       merged;
   logic              accept;
   logic              read_last;

   assign accept    = (state_q == StIdle) && start;
   assign read_last = (cnt_q == CntLast);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               unique case (size)
                  SizeWord: state_d = StWrite;
                  SizeByte: state_d = StRead;
                  SizeHalf: state_d = StRead;
                  default:  state_d = StError;
               endcase
            end
         end
         StRead: begin
            if (read_last) begin
               state_d = StCapture;
            end
         end
         StCapture: state_d = StWrite;
         StWrite:   state_d = StIdle;
         StError:   state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs decoded from state; reset masks the strobes so a write that
   // coincides with reset is never issued.
   always_comb begin
      busy   = (state_q != StIdle);
      mem_wr = (state_q == StWrite) && !reset;
      done   = ((state_q == StWrite) || (state_q == StError)) && !reset;
      err    = (state_q == StError) && !reset;
   end

   // Read-latency counter: held at zero outside READ so it is clear on entry.
   always_comb begin
      cnt_d = '0;
      if ((state_q == StRead) && !read_last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Latch the request once, in the accepting cycle; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         size_q <= '0;
         b_q    <= '0;
      end else if (accept) begin
         addr_q <= addr;
         size_q <= size;
         b_q    <= b_in;
      end
   end

   // Splice the low byte/halfword of the latched store data into the read word.
   always_comb begin
      if (size_q == SizeByte) begin
         merged = {mem_rdata[31:8], b_q[7:0]};
      end else begin
         merged = {mem_rdata[31:16], b_q[15:0]};
      end
   end

   // Write data: B for a word store, merged word after CAPTURE; otherwise hold.
   always_comb begin
      wdata_d = wdata_q;
      if (accept && (size == SizeWord)) begin
         wdata_d = b_in;
      end else if (state_q == StCapture) begin
         wdata_d = merged;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdata_q <= '0;
      end else begin
         wdata_q <= wdata_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule
